// File: rtl/mem_access_pkg.sv
// Shared types and helpers for the load/store sequencer between the control unit
// and the 64-bit data memory.
package mem_access_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_WRITE,
      ST_DONE
   } state_e;

   localparam int MEM_LAT_MIN = 1;
   localparam int MEM_LAT_MAX = 15;

   function automatic logic is_misaligned(size_e size, logic [2:0] offset);
      case (size)
         SZ_H:    return offset[0];
         SZ_W:    return |offset[1:0];
         SZ_D:    return |offset;
         default: return 1'b0;
      endcase
   endfunction

   // Byte lanes touched by an aligned access of the given size at this offset.
   function automatic logic [7:0] lane_mask(size_e size, logic [2:0] offset);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         SZ_W:    base = 8'h0F;
         default: base = 8'hFF;
      endcase
      return base << offset;
   endfunction

endpackage

// File: rtl/mem_access_ctrl_lane.sv
// Little-endian lane steering: merges store bytes into a read dword and
// extracts/extends load bytes from a dword.
module ls_lane_unit
   import mem_access_pkg::*;
(
   input  logic [63:0] mem_dword,
   input  logic [63:0] wdata,
   input  size_e       size,
   input  logic [2:0]  offset,
   input  logic        is_unsigned,
   output logic [63:0] merged,
   output logic [63:0] extended
);

   logic [63:0] wdata_shifted;
   logic [63:0] rd_shifted;
   logic [7:0]  mask;

   assign wdata_shifted = wdata << {offset, 3'b000};
   assign rd_shifted    = mem_dword >> {offset, 3'b000};
   assign mask          = lane_mask(size, offset);

   // Only the selected lanes take store data; every other byte keeps memory contents.
   always_comb begin
      merged = mem_dword;
      for (int i = 0; i < 8; i++) begin
         if (mask[i]) begin
            merged[8*i +: 8] = wdata_shifted[8*i +: 8];
         end
      end
   end

   always_comb begin
      extended = rd_shifted;
      case (size)
         SZ_B: extended = is_unsigned ? {56'b0, rd_shifted[7:0]}
                                      : {{56{rd_shifted[7]}}, rd_shifted[7:0]};
         SZ_H: extended = is_unsigned ? {48'b0, rd_shifted[15:0]}
                                      : {{48{rd_shifted[15]}}, rd_shifted[15:0]};
         SZ_W: extended = is_unsigned ? {32'b0, rd_shifted[31:0]}
                                      : {{32{rd_shifted[31]}}, rd_shifted[31:0]};
         default: extended = mem_dword;
      endcase
   end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store sequencer: accepts one access, waits out memory read latency, does
// read-modify-write for sub-dword stores and extends sub-dword loads.
module mem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int MEM_LAT = 1
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req,
   input  logic        req_store,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        busy,
   output logic        done,
   output logic        misaligned,
   output logic [63:0] rdata,
   output logic [63:0] mem_addr,
   output logic [63:0] mem_wdata,
   output logic        mem_wr,
   input  logic [63:0] mem_rdata
);

   if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_lat_check
      $error("mem_access_ctrl: MEM_LAT out of range 1..15");
   end

   localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

   state_e      state;
   size_e       size_q;
   logic        store_q;
   logic        unsigned_q;
   logic [2:0]  offset_q;
   logic [63:0] wdata_q;
   logic [3:0]  lat_cnt;
   logic [63:0] merged;
   logic [63:0] extended;

   ls_lane_unit u_lane (
      .mem_dword   (mem_rdata),
      .wdata       (wdata_q),
      .size        (size_q),
      .offset      (offset_q),
      .is_unsigned (unsigned_q),
      .merged      (merged),
      .extended    (extended)
   );

   // Sequencer FSM; outputs are registered alongside the state so mem_wr is high
   // exactly while in WRITE and clears asynchronously with RESET.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         misaligned <= 1'b0;
         mem_wr     <= 1'b0;
         rdata      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         size_q     <= SZ_B;
         store_q    <= 1'b0;
         unsigned_q <= 1'b0;
         offset_q   <= '0;
         wdata_q    <= '0;
         lat_cnt    <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req) begin
                  size_q     <= size_e'(req_size);
                  store_q    <= req_store;
                  unsigned_q <= req_unsigned;
                  offset_q   <= req_addr[2:0];
                  wdata_q    <= req_wdata;
                  mem_addr   <= {req_addr[63:3], 3'b000};
                  lat_cnt    <= LAT_LOAD;
                  busy       <= 1'b1;
                  if (is_misaligned(size_e'(req_size), req_addr[2:0])) begin
                     misaligned <= 1'b1;
                     done       <= 1'b1;
                     state      <= ST_DONE;
                  end else if (req_store && size_e'(req_size) == SZ_D) begin
                     mem_wdata <= req_wdata;
                     mem_wr    <= 1'b1;
                     state     <= ST_WRITE;
                  end else begin
                     state <= ST_READ;
                  end
               end
            end
            ST_READ: begin
               if (lat_cnt == 4'd0) begin
                  if (store_q) begin
                     mem_wdata <= merged;
                     mem_wr    <= 1'b1;
                     state     <= ST_WRITE;
                  end else begin
                     rdata <= extended;
                     done  <= 1'b1;
                     state <= ST_DONE;
                  end
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            ST_WRITE: begin
               mem_wr <= 1'b0;
               done   <= 1'b1;
               state  <= ST_DONE;
            end
            ST_DONE: begin
               done       <= 1'b0;
               busy       <= 1'b0;
               misaligned <= 1'b0;
               state      <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: scoreboarded accesses against a
// small word-addressed memory model with MEM_LAT = 2.
module tb_mem_access_ctrl;

   localparam int LAT = 2;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req;
   logic        req_store;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic        busy;
   logic        done;
   logic        misaligned;
   logic [63:0] rdata;
   logic [63:0] mem_addr;
   logic [63:0] mem_wdata;
   logic        mem_wr;
   logic [63:0] mem_rdata;

   logic [63:0] mem [0:63];
   logic        preload;

   typedef struct {
      string       tag;
      int          lat;
      logic [63:0] rdata;
      logic        mis;
      int          wr;
   } exp_t;

   exp_t sb_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   mem_access_ctrl #(.MEM_LAT(LAT)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .req          (req),
      .req_store    (req_store),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .busy         (busy),
      .done         (done),
      .misaligned   (misaligned),
      .rdata        (rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_wr       (mem_wr),
      .mem_rdata    (mem_rdata)
   );

   always #5 CLK = ~CLK;

   assign mem_rdata = mem[mem_addr[8:3]];

   always @(posedge CLK) begin
      if (preload) begin
         mem[32] <= 64'h1122334488_99AABB;
         mem[33] <= 64'h0;
      end else if (mem_wr) begin
         mem[mem_addr[8:3]] <= mem_wdata;
      end
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one request at cycle 0 and follows it to done, then checks the scoreboard entry.
   task automatic apply_stimulus(input string tag, input logic st, input logic [1:0] sz,
                                 input logic uns, input logic [63:0] addr, input logic [63:0] wd,
                                 input logic [63:0] exp_rd, input int exp_lat, input logic exp_mis,
                                 input logic pulse_again);
      exp_t        e;
      int          done_cyc;
      int          wrs;
      int          extra_done;
      logic        mis_seen;
      logic [63:0] rd_seen;
      e.tag   = tag;
      e.lat   = exp_lat;
      e.rdata = exp_rd;
      e.mis   = exp_mis;
      e.wr    = (st && !exp_mis) ? 1 : 0;
      sb_q.push_back(e);
      req          = 1'b1;
      req_store    = st;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      @(posedge CLK);
      @(negedge CLK);
      req        = pulse_again;
      done_cyc   = -1;
      wrs        = 0;
      extra_done = 0;
      mis_seen   = 1'b0;
      rd_seen    = '0;
      for (int cyc = 1; cyc <= 40; cyc++) begin
         if (cyc == 1) begin
            check_output({tag, " busy"}, {63'b0, busy}, 64'd1);
            check_output({tag, " mem_addr"}, mem_addr, {addr[63:3], 3'b000});
         end
         if (mem_wr) wrs++;
         if (done) begin
            done_cyc = cyc;
            mis_seen = misaligned;
            rd_seen  = rdata;
            break;
         end
         @(posedge CLK);
         @(negedge CLK);
         req = 1'b0;
      end
      req = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge CLK);
         @(negedge CLK);
         if (done) extra_done++;
         if (mem_wr) wrs++;
      end
      e = sb_q.pop_front();
      if (done_cyc < 0) check_output({e.tag, " timeout"}, 64'd1, 64'd0);
      check_output({e.tag, " done_cycle"}, 64'(done_cyc), 64'(e.lat));
      check_output({e.tag, " rdata"}, rd_seen, e.rdata);
      check_output({e.tag, " misaligned"}, {63'b0, mis_seen}, {63'b0, e.mis});
      check_output({e.tag, " writes"}, 64'(wrs), 64'(e.wr));
      check_output({e.tag, " extra_done"}, 64'(extra_done), 64'd0);
      check_output({e.tag, " idle_busy"}, {63'b0, busy}, 64'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      RESET        = 1'b1;
      preload      = 1'b1;
      req          = 1'b0;
      req_store    = 1'b0;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = '0;
      req_wdata    = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      preload = 1'b0;
      check_output("reset busy", {63'b0, busy}, 64'd0);
      check_output("reset done", {63'b0, done}, 64'd0);
      check_output("reset mem_wr", {63'b0, mem_wr}, 64'd0);
      check_output("reset misaligned", {63'b0, misaligned}, 64'd0);
      check_output("reset rdata", rdata, 64'd0);
      check_output("reset mem_addr", mem_addr, 64'd0);
      check_output("reset mem_wdata", mem_wdata, 64'd0);
      RESET = 1'b0;
      @(negedge CLK);

      apply_stimulus("lw@100", 1'b0, 2'b10, 1'b0, 64'h100, 64'h0, 64'hFFFFFFFF8899AABB, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lbu@107", 1'b0, 2'b00, 1'b1, 64'h107, 64'h0, 64'h0000000000000011, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lb@103", 1'b0, 2'b00, 1'b0, 64'h103, 64'h0, 64'hFFFFFFFFFFFFFF88, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lhu@106", 1'b0, 2'b01, 1'b1, 64'h106, 64'h0, 64'h0000000000001122, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("sb@101", 1'b1, 2'b00, 1'b0, 64'h101, 64'hFFFFFFFFFFFFFFEE, 64'h1122, LAT + 2, 1'b0, 1'b0);
      check_output("sb@101 mem", mem[32], 64'h112233448899EEBB);
      apply_stimulus("sh@103", 1'b1, 2'b01, 1'b0, 64'h103, 64'h7777, 64'h1122, 1, 1'b1, 1'b0);
      check_output("sh@103 mem", mem[32], 64'h112233448899EEBB);
      apply_stimulus("sd@108", 1'b1, 2'b11, 1'b0, 64'h108, 64'hDEADBEEFCAFEF00D, 64'h1122, 2, 1'b0, 1'b1);
      check_output("sd@108 mem", mem[33], 64'hDEADBEEFCAFEF00D);

      // Reset lands while the sub-dword store sits in WRITE; no write may follow.
      req          = 1'b1;
      req_store    = 1'b1;
      req_size     = 2'b00;
      req_unsigned = 1'b0;
      req_addr     = 64'h101;
      req_wdata    = 64'h55;
      @(posedge CLK);
      @(negedge CLK);
      req = 1'b0;
      for (int i = 0; i < 20 && !mem_wr; i++) begin
         @(posedge CLK);
         @(negedge CLK);
      end
      check_output("rst pre mem_wr", {63'b0, mem_wr}, 64'd1);
      #1 RESET = 1'b1;
      #1;
      check_output("rst mem_wr", {63'b0, mem_wr}, 64'd0);
      check_output("rst busy", {63'b0, busy}, 64'd0);
      check_output("rst done", {63'b0, done}, 64'd0);
      @(posedge CLK);
      @(negedge CLK);
      RESET = 1'b0;
      check_output("rst mem", mem[32], 64'h112233448899EEBB);
      check_output("rst rdata", rdata, 64'd0);
      @(negedge CLK);

      apply_stimulus("ld@100", 1'b0, 2'b11, 1'b1, 64'h100, 64'h0, 64'h112233448899EEBB, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("sw@104", 1'b1, 2'b10, 1'b0, 64'h104, 64'hFFFFFFFF0BADF00D, 64'h112233448899EEBB, LAT + 2, 1'b0, 1'b0);
      check_output("sw@104 mem", mem[32], 64'h0BADF00D8899EEBB);
      apply_stimulus("lw@104", 1'b0, 2'b10, 1'b0, 64'h104, 64'h0, 64'h000000000BADF00D, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lw@10C", 1'b0, 2'b10, 1'b0, 64'h10C, 64'h0, 64'hFFFFFFFFDEADBEEF, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lwu@10C", 1'b0, 2'b10, 1'b1, 64'h10C, 64'h0, 64'h00000000DEADBEEF, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("lh@10A", 1'b0, 2'b01, 1'b0, 64'h10A, 64'h0, 64'hFFFFFFFFFFFFCAFE, LAT + 1, 1'b0, 1'b0);
      apply_stimulus("ld@10C", 1'b0, 2'b11, 1'b0, 64'h10C, 64'h0, 64'hFFFFFFFFFFFFCAFE, 1, 1'b1, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
